// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and helpers for the 5-stage MIPS core controllers.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       regdst;
        logic       branch;
        logic       jump;
        logic       jr;
        logic       finish;
        logic       uses_rt;
        logic [3:0] aluop;
    } dec_ctrl_t;

    // $zero is hardwired, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : ID/EX/MEM hazard inputs and pipeline control outputs.
// Revision : 1.0
// ============================================================================
interface pipe_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_branch;
    logic       id_jump;
    logic       id_jr;
    logic       id_finish;
    logic       id_branch_taken;
    logic       ex_memread;
    logic       ex_regwrite;
    logic [4:0] ex_wreg;
    logic       mem_memread;
    logic [4:0] mem_wreg;
    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       halted;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_branch, id_jump, id_jr, id_finish,
               id_branch_taken, ex_memread, ex_regwrite, ex_wreg, mem_memread, mem_wreg,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, halted
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_branch, id_jump, id_jr, id_finish,
               id_branch_taken, ex_memread, ex_regwrite, ex_wreg, mem_memread, mem_wreg,
        output pc_we, ifid_we, ifid_flush, idex_bubble, halted
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_detect
// Brief    : Combinational load-use and branch-operand hazard detection.
// Revision : 1.0
// ============================================================================
module pipe_hazard_detect
    import cpu_pkg::*;
(
    input  wire logic [4:0] id_rs,
    input  wire logic [4:0] id_rt,
    input  wire logic       id_uses_rt,
    input  wire logic       id_branch,
    input  wire logic       id_jr,
    input  wire logic       ex_memread,
    input  wire logic       ex_regwrite,
    input  wire logic [4:0] ex_wreg,
    input  wire logic       mem_memread,
    input  wire logic [4:0] mem_wreg,
    output logic            load_use,
    output logic            br_dep,
    output logic            stall
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = reg_match(id_rs, ex_wreg)  || (id_uses_rt && reg_match(id_rt, ex_wreg));
    assign w_mem_hit = reg_match(id_rs, mem_wreg) || (id_uses_rt && reg_match(id_rt, mem_wreg));

    // Branches resolve in ID, so they also wait on ALU results in EX and loads in MEM.
    assign load_use = ex_memread && w_ex_hit;
    assign br_dep   = (id_branch || id_jr) &&
                      ((ex_regwrite && w_ex_hit) || (mem_memread && w_mem_hit));
    assign stall    = load_use || br_dep;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline sequencing controller: stalls, flushes, syscall drain/halt.
// Revision : 1.0
// ============================================================================
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipe_ctrl_if.slave            bus,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ctrl_state_e          r_state;
    logic [c_DRAIN_W-1:0] r_drain;
    logic                 r_halted;
    logic [CNT_W-1:0]     r_cycle_cnt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;

    logic w_load_use;
    logic w_br_dep;
    logic w_stall;
    logic w_redirect;
    logic w_stall_run;
    logic w_finish_run;
    logic w_redirect_run;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_flush;
    logic w_bubble;
    logic unused_hz;

    pipe_hazard_detect u_hazard (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .id_branch   (bus.id_branch),
        .id_jr       (bus.id_jr),
        .ex_memread  (bus.ex_memread),
        .ex_regwrite (bus.ex_regwrite),
        .ex_wreg     (bus.ex_wreg),
        .mem_memread (bus.mem_memread),
        .mem_wreg    (bus.mem_wreg),
        .load_use    (w_load_use),
        .br_dep      (w_br_dep),
        .stall       (w_stall)
    );

    assign unused_hz  = w_load_use ^ w_br_dep;
    assign w_redirect = bus.id_jump || bus.id_jr || (bus.id_branch && bus.id_branch_taken);

    // Reset, DRAIN and HALT all freeze fetch and feed NOPs into both latches.
    always_comb begin
        w_pc_we        = 1'b0;
        w_ifid_we      = 1'b0;
        w_flush        = 1'b1;
        w_bubble       = 1'b1;
        w_stall_run    = 1'b0;
        w_finish_run   = 1'b0;
        w_redirect_run = 1'b0;
        if (!rst && r_state == RUN) begin
            if (w_stall) begin
                w_stall_run = 1'b1;
                w_flush     = 1'b0;
            end else if (bus.id_finish) begin
                w_finish_run = 1'b1;
            end else if (w_redirect) begin
                w_redirect_run = 1'b1;
                w_pc_we        = 1'b1;
                w_ifid_we      = 1'b1;
                w_bubble       = 1'b0;
            end else begin
                w_pc_we   = 1'b1;
                w_ifid_we = 1'b1;
                w_flush   = 1'b0;
                w_bubble  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_drain     <= '0;
            r_halted    <= 1'b0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_finish_run) begin
                        r_state <= DRAIN;
                        r_drain <= c_DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (r_drain == '0) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain <= r_drain - c_DRAIN_W'(1);
                    end
                end
                HALT: begin
                end
                default: r_state <= RUN;
            endcase

            if (r_state != HALT && r_cycle_cnt != '1)
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_stall_run && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_redirect_run && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.ifid_we     = w_ifid_we;
    assign bus.ifid_flush  = w_flush;
    assign bus.idex_bubble = w_bubble;
    assign bus.halted      = r_halted;
    assign cycle_cnt       = r_cycle_cnt;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed scoreboard bench for pipe_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl;

    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 8;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       branch;
        logic       jump;
        logic       jr;
        logic       finish;
        logic       taken;
        logic       ex_memread;
        logic       ex_regwrite;
        logic [4:0] ex_wreg;
        logic       mem_memread;
        logic [4:0] mem_wreg;
    } vin_t;

    typedef struct {
        int         id;
        logic [3:0] ctl;   // {pc_we, ifid_we, ifid_flush, idex_bubble}
        logic [3:0] mask;
        bit         chk_st;
        logic       halted;
        int         cyc;
        int         stl;
        int         fls;
    } vexp_t;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vexp_t q[$];
    vexp_t e_mon;
    int    total = 0;
    int    bad   = 0;
    int    vec_id = 0;

    task automatic chk(input int id, input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL vec%0d %s actual=%0d want=%0d", id, nm, act, want);
        end
    endtask

    // Monitor: outputs are presented every cycle a vector is live.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e_mon = q.pop_front();
            if (e_mon.mask[3]) chk(e_mon.id, "pc_we",       int'(bus.pc_we),       int'(e_mon.ctl[3]));
            if (e_mon.mask[2]) chk(e_mon.id, "ifid_we",     int'(bus.ifid_we),     int'(e_mon.ctl[2]));
            if (e_mon.mask[1]) chk(e_mon.id, "ifid_flush",  int'(bus.ifid_flush),  int'(e_mon.ctl[1]));
            if (e_mon.mask[0]) chk(e_mon.id, "idex_bubble", int'(bus.idex_bubble), int'(e_mon.ctl[0]));
            if (e_mon.chk_st) begin
                chk(e_mon.id, "halted",    int'(bus.halted), int'(e_mon.halted));
                chk(e_mon.id, "cycle_cnt", int'(cycle_cnt),  e_mon.cyc);
                chk(e_mon.id, "stall_cnt", int'(stall_cnt),  e_mon.stl);
                chk(e_mon.id, "flush_cnt", int'(flush_cnt),  e_mon.fls);
            end
        end
    end

    task automatic apply(input vin_t v);
        rst                 = v.rst;
        bus.id_rs           = v.rs;
        bus.id_rt           = v.rt;
        bus.id_uses_rt      = v.uses_rt;
        bus.id_branch       = v.branch;
        bus.id_jump         = v.jump;
        bus.id_jr           = v.jr;
        bus.id_finish       = v.finish;
        bus.id_branch_taken = v.taken;
        bus.ex_memread      = v.ex_memread;
        bus.ex_regwrite     = v.ex_regwrite;
        bus.ex_wreg         = v.ex_wreg;
        bus.mem_memread     = v.mem_memread;
        bus.mem_wreg        = v.mem_wreg;
    endtask

    task automatic step(input vin_t v, input logic [3:0] ctl, input logic [3:0] mask,
                        input bit chk_st, input logic h, input int cyc, input int stl, input int fls);
        vexp_t e;
        @(posedge clk);
        #1;
        apply(v);
        e.id = vec_id; e.ctl = ctl; e.mask = mask; e.chk_st = chk_st;
        e.halted = h; e.cyc = cyc; e.stl = stl; e.fls = fls;
        vec_id++;
        q.push_back(e);
    endtask

    localparam logic [3:0] RSTO = 4'b0011;  // reset / drain / halt outputs
    localparam logic [3:0] NORM = 4'b1100;
    localparam logic [3:0] STAL = 4'b0001;
    localparam logic [3:0] REDR = 4'b1110;
    localparam logic [3:0] ALL  = 4'b1111;

    vin_t v;
    vin_t nop;
    int   wait_n;

    initial begin
        nop = '0;
        v = nop; v.rst = 1'b1;
        apply(v);

        // reset held
        step(v, RSTO, ALL, 1'b0, 1'b0, 0, 0, 0);
        step(v, RSTO, ALL, 1'b1, 1'b0, 0, 0, 0);
        step(nop, NORM, ALL, 1'b1, 1'b0, 0, 0, 0);
        // load-use on rs
        v = nop; v.ex_memread = 1; v.ex_wreg = 5'd8; v.rs = 5'd8;
        step(v, STAL, ALL, 1'b1, 1'b0, 1, 0, 0);
        step(nop, NORM, ALL, 1'b1, 1'b0, 2, 1, 0);
        // beq $8,$9 behind lw $8: EX load, then MEM load, then taken
        v = nop; v.branch = 1; v.taken = 1; v.rs = 5'd8; v.rt = 5'd9; v.uses_rt = 1;
        v.ex_memread = 1; v.ex_regwrite = 1; v.ex_wreg = 5'd8;
        step(v, STAL, ALL, 1'b1, 1'b0, 3, 1, 0);
        v.ex_memread = 0; v.ex_regwrite = 0; v.ex_wreg = 0; v.mem_memread = 1; v.mem_wreg = 5'd8;
        step(v, STAL, ALL, 1'b1, 1'b0, 4, 2, 0);
        v.mem_memread = 0; v.mem_wreg = 0;
        step(v, REDR, 4'b1110, 1'b1, 1'b0, 5, 3, 0);
        step(nop, NORM, ALL, 1'b1, 1'b0, 6, 3, 1);
        // $zero never matches
        v = nop; v.ex_memread = 1; v.ex_wreg = 5'd0; v.rs = 5'd0;
        step(v, NORM, ALL, 1'b1, 1'b0, 7, 3, 1);
        // j: rt matches load in EX but is not read
        v = nop; v.jump = 1; v.rt = 5'd8; v.ex_memread = 1; v.ex_wreg = 5'd8;
        step(v, REDR, 4'b1110, 1'b1, 1'b0, 8, 3, 1);
        step(nop, NORM, ALL, 1'b1, 1'b0, 9, 3, 2);
        // jr stalled on ALU result in EX, then redirects
        v = nop; v.jr = 1; v.rs = 5'd5; v.ex_regwrite = 1; v.ex_wreg = 5'd5;
        step(v, STAL, ALL, 1'b1, 1'b0, 10, 3, 2);
        v.ex_regwrite = 0; v.ex_wreg = 0;
        step(v, REDR, 4'b1110, 1'b1, 1'b0, 11, 4, 2);
        // non-load in MEM, untaken branch: no hazard
        v = nop; v.branch = 1; v.rs = 5'd5; v.mem_wreg = 5'd5;
        step(v, NORM, ALL, 1'b1, 1'b0, 12, 4, 3);
        // ALU result in EX with non-branch consumer: forwarded, no stall
        v = nop; v.rs = 5'd7; v.ex_regwrite = 1; v.ex_wreg = 5'd7;
        step(v, NORM, ALL, 1'b1, 1'b0, 13, 4, 3);
        // untaken beq reading rt from EX ALU result
        v = nop; v.branch = 1; v.rt = 5'd7; v.uses_rt = 1; v.ex_regwrite = 1; v.ex_wreg = 5'd7;
        step(v, STAL, ALL, 1'b1, 1'b0, 14, 4, 3);
        // syscall stalled by load-use, then accepted
        v = nop; v.finish = 1; v.rs = 5'd4; v.ex_memread = 1; v.ex_wreg = 5'd4;
        step(v, STAL, ALL, 1'b1, 1'b0, 15, 5, 3);
        v = nop; v.finish = 1;
        step(v, RSTO, 4'b1011, 1'b1, 1'b0, 16, 6, 3);
        // drain: redirect input must be ignored
        v = nop; v.jump = 1;
        step(v,   RSTO, ALL, 1'b1, 1'b0, 17, 6, 3);
        step(nop, RSTO, ALL, 1'b1, 1'b0, 18, 6, 3);
        step(nop, RSTO, ALL, 1'b1, 1'b0, 19, 6, 3);
        // halted, counters frozen
        step(nop, RSTO, ALL, 1'b1, 1'b1, 20, 6, 3);
        step(nop, RSTO, ALL, 1'b1, 1'b1, 20, 6, 3);
        v = nop; v.ex_memread = 1; v.ex_wreg = 5'd3; v.rs = 5'd3;
        step(v,   RSTO, ALL, 1'b1, 1'b1, 20, 6, 3);
        // reset out of HALT
        v = nop; v.rst = 1;
        step(v,   RSTO, ALL, 1'b1, 1'b1, 20, 6, 3);
        step(nop, NORM, ALL, 1'b1, 1'b0, 0, 0, 0);
        // finish then reset mid-drain
        v = nop; v.finish = 1;
        step(v,   RSTO, 4'b1011, 1'b1, 1'b0, 1, 0, 0);
        step(nop, RSTO, ALL, 1'b1, 1'b0, 2, 0, 0);
        v = nop; v.rst = 1;
        step(v,   RSTO, ALL, 1'b1, 1'b0, 3, 0, 0);
        step(nop, NORM, ALL, 1'b1, 1'b0, 0, 0, 0);
        // run long enough to saturate the 8-bit cycle counter
        repeat (300) @(posedge clk);
        step(nop, NORM, ALL, 1'b1, 1'b0, 255, 0, 0);

        wait_n = 0;
        while (q.size() != 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain_queue actual=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
